// File: rtl/peak_window_4bit.sv
// Windowed peak detector: tracks the max 4-bit sample and its first index over WIN accepted samples.
// Latency: result valid the cycle after the last sample of a window is accepted; comparator is combinational.
// Backpressure: one held result; while it waits on m_ready, s_ready is low and input is fully stalled.
module peak_window_4bit #(
    parameter int WIN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [3:0] s_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [3:0] m_peak,
    output logic [3:0] m_index
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(WIN - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] peak;
    logic [3:0] pidx;
    logic [3:0] cnt;
    logic       accept;
    logic       emit;
    logic       gt;
    logic       last;

    assign s_ready = (state != HOLD);
    assign m_valid = (state == HOLD);
    assign m_peak  = peak;
    assign m_index = pidx;

    assign accept = s_valid & s_ready;
    assign emit   = m_valid & m_ready;
    // Strict compare: ties keep the earlier index.
    assign gt     = (s_data > peak);
    assign last   = (cnt == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (accept) state_nxt = ACCUM;
                ACCUM:   if (accept && last) state_nxt = HOLD;
                HOLD:    if (emit) state_nxt = EMPTY;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak <= 4'd0;
            pidx <= 4'd0;
            cnt  <= 4'd0;
        end else if (clear) begin
            peak <= 4'd0;
            pidx <= 4'd0;
            cnt  <= 4'd0;
        end else if (accept) begin
            if (state == EMPTY) begin
                peak <= s_data;
                pidx <= 4'd0;
                cnt  <= 4'd1;
            end else begin
                if (gt) begin
                    peak <= s_data;
                    pidx <= cnt;
                end
                cnt <= last ? 4'd0 : cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_peak_window_4bit.sv
// Directed bench for peak_window_4bit (WIN=8): inputs change 1ns after rising edges, outputs checked there too.
module tb_peak_window_4bit;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] m_peak;
    logic [3:0] m_index;

    int n_checks = 0;
    int n_fail   = 0;
    int waited;

    peak_window_4bit #(.WIN(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_peak  (m_peak),
        .m_index (m_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and return after the edge that accepts it (bounded wait).
    task automatic push(input logic [3:0] d, output int w);
        w = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && w < 20) begin
            step();
            w++;
        end
        if (!s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, w);
        end
        step();
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = 4'd0; m_ready = 1'b0;
        step(); step();
        n_checks++;
        if ({s_ready, m_valid, m_peak, m_index} !== {1'b1, 1'b0, 4'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%0b vld=%0b peak=%0d idx=%0d, required 1 0 0 0",
                     s_ready, m_valid, m_peak, m_index);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] v [8];
        v = '{4'd3, 4'd7, 4'd2, 4'd7, 4'd9, 4'd1, 4'd9, 4'd0};
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(v[i], waited);
        n_checks++;
        if ({m_valid, s_ready, m_peak, m_index} !== {1'b1, 1'b0, 4'd9, 4'd4}) begin
            n_fail++;
            $display("FAIL basic_result: vld=%0b rdy=%0b peak=%0d idx=%0d, required 1 0 9 4",
                     m_valid, s_ready, m_peak, m_index);
        end
        step();
        n_checks++;
        if ({m_valid, s_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_one_cycle: vld=%0b rdy=%0b, required 0 1", m_valid, s_ready);
        end
    endtask

    task automatic test_ties();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(4'd5, waited);
        n_checks++;
        if ({m_valid, m_peak, m_index} !== {1'b1, 4'd5, 4'd0}) begin
            n_fail++;
            $display("FAIL tie_result: vld=%0b peak=%0d idx=%0d, required 1 5 0", m_valid, m_peak, m_index);
        end
        step();
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(4'(i), waited);
        n_checks++;
        if ({m_valid, m_peak, m_index} !== {1'b1, 4'd7, 4'd7}) begin
            n_fail++;
            $display("FAIL mono_up_result: vld=%0b peak=%0d idx=%0d, required 1 7 7", m_valid, m_peak, m_index);
        end
        push(4'd15, waited);
        n_checks++;
        if (waited != 1) begin
            n_fail++;
            $display("FAIL b2b_gap: first accept waited %0d cycles, required 1", waited);
        end
        for (int i = 14; i >= 8; i--) push(4'(i), waited);
        n_checks++;
        if ({m_valid, m_peak, m_index} !== {1'b1, 4'd15, 4'd0}) begin
            n_fail++;
            $display("FAIL mono_down_result: vld=%0b peak=%0d idx=%0d, required 1 15 0", m_valid, m_peak, m_index);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [3:0] v [8];
        v = '{4'd4, 4'd11, 4'd6, 4'd11, 4'd2, 4'd0, 4'd3, 4'd1};
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(v[i], waited);
        s_valid = 1'b1;
        s_data  = 4'd13;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({s_ready, m_valid, m_peak, m_index} !== {1'b0, 1'b1, 4'd11, 4'd1}) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: rdy=%0b vld=%0b peak=%0d idx=%0d, required 0 1 11 1",
                         c, s_ready, m_valid, m_peak, m_index);
            end
            step();
        end
        m_ready = 1'b1;
        step();
        n_checks++;
        if ({s_ready, m_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_release: rdy=%0b vld=%0b, required 1 0", s_ready, m_valid);
        end
        step();
        s_valid = 1'b0;
        for (int i = 0; i < 7; i++) push(4'd0, waited);
        n_checks++;
        if ({m_valid, m_peak, m_index} !== {1'b1, 4'd13, 4'd0}) begin
            n_fail++;
            $display("FAIL held_sample_once: vld=%0b peak=%0d idx=%0d, required 1 13 0", m_valid, m_peak, m_index);
        end
        step();
    endtask

    task automatic test_clear();
        logic [3:0] a [4];
        a = '{4'd10, 4'd12, 4'd3, 4'd4};
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(a[i], waited);
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_checks++;
        if ({s_ready, m_valid, m_peak, m_index} !== {1'b1, 1'b0, 4'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL clear_partial: rdy=%0b vld=%0b peak=%0d idx=%0d, required 1 0 0 0",
                     s_ready, m_valid, m_peak, m_index);
        end
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push((i % 2 == 0) ? 4'd1 : 4'd2, waited);
        n_checks++;
        if ({m_valid, m_peak, m_index} !== {1'b1, 4'd2, 4'd1}) begin
            n_fail++;
            $display("FAIL clear_after_result: vld=%0b peak=%0d idx=%0d, required 1 2 1", m_valid, m_peak, m_index);
        end
        clear   = 1'b1;
        m_ready = 1'b1;
        step();
        clear = 1'b0;
        n_checks++;
        if ({s_ready, m_valid, m_peak, m_index} !== {1'b1, 1'b0, 4'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL clear_in_hold: rdy=%0b vld=%0b peak=%0d idx=%0d, required 1 0 0 0",
                     s_ready, m_valid, m_peak, m_index);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] v [8];
        v = '{4'd6, 4'd3, 4'd8, 4'd1, 4'd8, 4'd2, 4'd0, 4'd4};
        m_ready = 1'b1;
        push(4'd14, waited);
        push(4'd15, waited);
        push(4'd2, waited);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({s_ready, m_valid, m_peak, m_index} !== {1'b1, 1'b0, 4'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL async_reset: rdy=%0b vld=%0b peak=%0d idx=%0d, required 1 0 0 0",
                     s_ready, m_valid, m_peak, m_index);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) push(v[i], waited);
        n_checks++;
        if ({m_valid, m_peak, m_index} !== {1'b1, 4'd8, 4'd2}) begin
            n_fail++;
            $display("FAIL post_reset_window: vld=%0b peak=%0d idx=%0d, required 1 8 2", m_valid, m_peak, m_index);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
